// File: rtl/blake2s_block_feeder.sv
// blake2s_block_feeder: packs a byte stream into zero-padded 64-byte BLAKE2s blocks.
// Optional: define BLAKE2S_FEEDER_PINGPONG_EN to fill one buffer while the other drains.
module blake2s_block_feeder #(
  parameter int BB = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  input  logic        msg_empty_i,
  output logic        ready_o,
  input  logic        hash_ready_i,
  output logic        data_v_o,
  output logic [7:0]  data_o,
  output logic [5:0]  data_idx_o,
  output logic        block_first_o,
  output logic        block_last_o,
  output logic [63:0] ll_o
);

`ifdef BLAKE2S_FEEDER_PINGPONG_EN
  localparam int   NB = 2;
  localparam logic PP = 1'b1;
`else
  localparam int   NB = 1;
  localparam logic PP = 1'b0;
`endif

  typedef enum logic [1:0] {FILL, WAIT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [7:0]    buf_q [NB][BB];
  logic [6:0]    cnt_q [NB];
  logic [6:0]    cnt_d [NB];
  logic [NB-1:0] full_q, full_d;
  logic [NB-1:0] lst_q, lst_d;
  logic [NB-1:0] fst_q, fst_d;
  logic          wp_q, wp_d;
  logic          rp_q, rp_d;
  logic          first_q, first_d;
  logic [5:0]    idx_q, idx_d;
  logic [63:0]   ll_q, ll_d;
  logic          acc, empty, fill_done, drain_done, lpend;

  // A pending last block stalls input so ll stays frozen until it drains.
  assign lpend      = |(full_q & lst_q);
  assign ready_o    = ~full_q[wp_q] & ~lpend;
  assign acc        = valid_i & ready_o;
  assign empty      = msg_empty_i & ~valid_i & ready_o
                    & (cnt_q[wp_q] == 7'd0);
  assign fill_done  = (acc & (last_i | (cnt_q[wp_q] == 7'd63)))
                    | empty;
  assign drain_done = (state_q == DRAIN) & (idx_q == 6'd63);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    full_d  = full_q;
    lst_d   = lst_q;
    fst_d   = fst_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    first_d = first_q;
    idx_d   = idx_q;
    ll_d    = ll_q;
    if (acc) begin
      cnt_d[wp_q] = cnt_q[wp_q] + 7'd1;
      ll_d        = ll_q + 64'd1;
    end
    if (fill_done) begin
      full_d[wp_q] = 1'b1;
      lst_d[wp_q]  = acc ? last_i : 1'b1;
      fst_d[wp_q]  = first_q;
      first_d      = acc ? last_i : 1'b1;
      wp_d         = wp_q ^ PP;
    end
    if (drain_done) begin
      full_d[rp_q] = 1'b0;
      cnt_d[rp_q]  = 7'd0;
      rp_d         = rp_q ^ PP;
      if (lst_q[rp_q]) ll_d = '0;
    end
    unique case (state_q)
      FILL:  if (full_d[rp_q]) state_d = WAIT;
      WAIT:  if (hash_ready_i) state_d = DRAIN;
      DRAIN: begin
        idx_d = idx_q + 6'd1;
        if (drain_done) state_d = full_d[rp_d] ? WAIT : FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      full_q  <= '0;
      lst_q   <= '0;
      fst_q   <= '0;
      wp_q    <= 1'b0;
      rp_q    <= 1'b0;
      first_q <= 1'b1;
      idx_q   <= '0;
      ll_q    <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      lst_q   <= lst_d;
      fst_q   <= fst_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      first_q <= first_d;
      idx_q   <= idx_d;
      ll_q    <= ll_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) buf_q[wp_q][cnt_q[wp_q][5:0]] <= data_i;
  end

  always_comb begin
    data_v_o   = 1'b0;
    data_o     = '0;
    data_idx_o = '0;
    if (state_q == DRAIN) begin
      data_v_o   = 1'b1;
      data_idx_o = idx_q;
      if ({1'b0, idx_q} < cnt_q[rp_q]) data_o = buf_q[rp_q][idx_q];
    end
  end

  assign block_first_o = (state_q == FILL) ? first_q : fst_q[rp_q];
  assign block_last_o  = (state_q != FILL) & lst_q[rp_q];
  assign ll_o          = ll_q;

endmodule

// File: tb/tb_blake2s_block_feeder.sv
// tb_blake2s_block_feeder: directed + random messages against a block-level
// reference (message sliced into 64-byte zero-padded blocks).
module tb_blake2s_block_feeder;
  logic        clk = 1'b0;
  logic        reset, valid_i, last_i, msg_empty_i, hash_ready_i;
  logic [7:0]  data_i, data_o;
  logic        ready_o, data_v_o, block_first_o, block_last_o;
  logic [5:0]  data_idx_o;
  logic [63:0] ll_o;

  int checks   = 0;
  int failures = 0;
  logic [7:0] msg [$];

  always #5 clk = ~clk;

  blake2s_block_feeder #(.BB(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .data_i       (data_i),
    .last_i       (last_i),
    .msg_empty_i  (msg_empty_i),
    .ready_o      (ready_o),
    .hash_ready_i (hash_ready_i),
    .data_v_o     (data_v_o),
    .data_o       (data_o),
    .data_idx_o   (data_idx_o),
    .block_first_o(block_first_o),
    .block_last_o (block_last_o),
    .ll_o         (ll_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle();
    chk("idle_v", data_v_o, 1'b0);
    chk("idle_data", data_o, 8'h00);
    chk("idle_idx", data_idx_o, 6'd0);
    chk("idle_rdy", ready_o, 1'b1);
    chk("idle_first", block_first_o, 1'b1);
    chk("idle_last", block_last_o, 1'b0);
    chk("idle_ll", ll_o, 64'd0);
  endtask

  // Sends msg, collecting every beat; hold>0 keeps hash_ready low
  // for that many cycles once the whole message has been accepted.
  task automatic run_msg(input int hold);
    int len, n, pos, beats, cyc, wc, blk, i;
    bit hr_rise, acc;
    logic [7:0] e;
    len = msg.size();
    n = (len == 0) ? 1 : (len + 63) / 64;
    pos = 0; beats = 0; cyc = 0; wc = 0; hr_rise = 0;
    hash_ready_i = (hold == 0);
    while (beats < n * 64 && cyc < 3000) begin
      if (hr_rise) begin
        chk("hr_latency", data_v_o, 1'b1);
        hr_rise = 0;
      end
      if (beats % 64 != 0) chk("beat_gap", data_v_o, 1'b1);
      if (data_v_o) begin
        blk = beats / 64;
        i   = beats % 64;
        e   = (blk * 64 + i < len) ? msg[blk * 64 + i] : 8'h00;
        chk("idx", data_idx_o, i);
        chk("data", data_o, e);
        chk("first", block_first_o, blk == 0);
        chk("last", block_last_o, blk == n - 1);
        if (blk == n - 1) chk("ll", ll_o, len);
        beats++;
      end
      if (!hash_ready_i && pos == len) begin
        chk("wait_v", data_v_o, 1'b0);
        chk("wait_rdy", ready_o, 1'b0);
        wc++;
        if (wc == hold) begin
          hash_ready_i = 1'b1;
          hr_rise = 1;
        end
      end
      valid_i = 0; last_i = 0; data_i = 0; msg_empty_i = 0;
      if (len == 0) msg_empty_i = (cyc == 0);
      else if (pos < len) begin
        valid_i = 1;
        data_i  = msg[pos];
        last_i  = (pos == len - 1);
      end
      acc = valid_i & ready_o;
      @(posedge clk);
      if (acc) pos++;
      @(negedge clk);
      cyc++;
    end
    chk("beats_total", beats, n * 64);
    valid_i = 0; last_i = 0; msg_empty_i = 0; hash_ready_i = 1;
    repeat (3) begin
      chk_idle();
      @(negedge clk);
    end
  endtask

  task automatic rand_msg(input int len);
    msg.delete();
    for (int k = 0; k < len; k++) msg.push_back(8'($urandom));
  endtask

  initial begin
    int t;
    reset = 1; valid_i = 0; last_i = 0; data_i = 0;
    msg_empty_i = 0; hash_ready_i = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle();
    reset = 0;

    msg.delete();
    msg.push_back(8'd61); msg.push_back(8'd62); msg.push_back(8'd63);
    run_msg(0);

    msg.delete();
    for (int k = 0; k < 64; k++) msg.push_back(8'(k));
    run_msg(0);

    rand_msg(65);  run_msg(0);
    msg.delete();  run_msg(0);
    rand_msg(3);   run_msg(0);
    rand_msg(64);  run_msg(10);
    rand_msg(128); run_msg(0);
    repeat (4) begin
      rand_msg($urandom_range(1, 200));
      run_msg(0);
    end

    // reset in the middle of a drain
    hash_ready_i = 1;
    for (int k = 0; k < 10; k++) begin
      valid_i = 1; data_i = 8'($urandom); last_i = (k == 9);
      @(posedge clk);
      @(negedge clk);
    end
    valid_i = 0; last_i = 0;
    t = 0;
    while (!(data_v_o && data_idx_o == 6'd20) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("reach_beat20", t < 300, 1'b1);
    reset = 1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_v", data_v_o, 1'b0);
    chk("rst_rdy", ready_o, 1'b1);
    chk("rst_first", block_first_o, 1'b1);
    chk("rst_ll", ll_o, 64'd0);
    reset = 0;
    rand_msg(3);
    run_msg(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
